// File: rtl/sram_lsu_bridge.sv
// Load/store bridge from the CPU memory stage to the 32-bit SRAM controller.
// Define SRAM_LSU_TIMEOUT_EN to bound the acknowledge wait by TIMEOUT_CYCLES.
module sram_lsu_bridge #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_wren,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [17:0] o_ADDR,
    output logic [31:0] o_WDATA,
    output logic [3:0]  o_BMASK,
    output logic        o_WREN,
    output logic        o_RDEN,
    input  logic [31:0] i_RDATA,
    input  logic        i_ACK
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_wren;
    logic        w_accept;
    logic        w_bad;
    logic        w_tmo;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_ldata;

`ifdef SRAM_LSU_TIMEOUT_EN
    logic [7:0] r_cnt;

    assign w_tmo = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cnt <= 8'd0;
        else if (r_state == WAIT)
            r_cnt <= r_cnt + 8'd1;
        else
            r_cnt <= 8'd0;
    end
`else
    assign w_tmo = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && i_req_valid;

    always_comb begin
        w_bad = (|i_req_addr[31:19]) || (i_req_size == 2'b11) ||
                ((i_req_size == 2'b01) && i_req_addr[0]) ||
                ((i_req_size == 2'b10) && (|i_req_addr[1:0]));
    end

    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = i_req_wdata;
        case (i_req_size)
            2'b00: begin
                w_mask  = 4'b0001 << i_req_addr[1:0];
                w_wdata = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_mask  = i_req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_req_wdata[15:0]}};
            end
            default: begin
                w_mask  = 4'b1111;
                w_wdata = i_req_wdata;
            end
        endcase
    end

    // Align the addressed lane to bit 0, then truncate and extend.
    assign w_shift = i_RDATA >> {r_lane, 3'b000};

    always_comb begin
        w_ldata = w_shift;
        case (r_size)
            2'b00:   w_ldata = r_uns ? {24'd0, w_shift[7:0]}
                                     : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_ldata = r_uns ? {16'd0, w_shift[15:0]}
                                     : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_ldata = w_shift;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_req_valid) w_next = w_bad ? RESP : ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (i_ACK || w_tmo) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_lane      <= 2'd0;
            r_size      <= 2'd0;
            r_uns       <= 1'b0;
            r_wren      <= 1'b0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
            o_ADDR      <= 18'd0;
            o_WDATA     <= 32'd0;
            o_BMASK     <= 4'd0;
            o_WREN      <= 1'b0;
            o_RDEN      <= 1'b0;
        end else begin
            r_state     <= w_next;
            o_req_ready <= (w_next == IDLE);
            o_rsp_valid <= (w_next == RESP);
            o_WREN      <= w_accept && !w_bad && i_req_wren;
            o_RDEN      <= w_accept && !w_bad && !i_req_wren;
            if (w_accept) begin
                r_lane      <= i_req_addr[1:0];
                r_size      <= i_req_size;
                r_uns       <= i_req_unsigned;
                r_wren      <= i_req_wren;
                o_rsp_err   <= w_bad;
                o_rsp_rdata <= 32'd0;
                if (!w_bad) begin
                    o_ADDR  <= {i_req_addr[18:2], 1'b0};
                    o_BMASK <= w_mask;
                    o_WDATA <= w_wdata;
                end
            end
            // ACK wins over a timeout that expires in the same cycle.
            if ((r_state == WAIT) && (w_next == RESP)) begin
                o_rsp_err   <= !i_ACK;
                o_rsp_rdata <= (i_ACK && !r_wren) ? w_ldata : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_sram_lsu_bridge.sv
// Directed testbench for sram_lsu_bridge.
// Controller acknowledges are driven by hand at the documented cycles.
module tb_sram_lsu_bridge;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_wren;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [17:0] o_ADDR;
    logic [31:0] o_WDATA;
    logic [3:0]  o_BMASK;
    logic        o_WREN;
    logic        o_RDEN;
    logic [31:0] i_RDATA;
    logic        i_ACK;

    int n_chk = 0;
    int n_err = 0;

    sram_lsu_bridge #(.TIMEOUT_CYCLES(15)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (i_req_addr),
        .i_req_wren     (i_req_wren),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_ADDR         (o_ADDR),
        .o_WDATA        (o_WDATA),
        .o_BMASK        (o_BMASK),
        .o_WREN         (o_WREN),
        .o_RDEN         (o_RDEN),
        .i_RDATA        (i_RDATA),
        .i_ACK          (i_ACK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, 32'(o_req_ready), 32'd1);
        chk({tag, ".rspv"},  32'(o_rsp_valid), 32'd0);
        chk({tag, ".rdata"}, o_rsp_rdata, 32'd0);
        chk({tag, ".err"},   32'(o_rsp_err), 32'd0);
        chk({tag, ".addr"},  32'(o_ADDR), 32'd0);
        chk({tag, ".wdata"}, o_WDATA, 32'd0);
        chk({tag, ".bmask"}, 32'(o_BMASK), 32'd0);
        chk({tag, ".wren"},  32'(o_WREN), 32'd0);
        chk({tag, ".rden"},  32'(o_RDEN), 32'd0);
    endtask

    // Present one request in the current cycle (cycle 0) and follow it
    // to the response; ack_cyc = 0 means the controller never answers.
    task automatic xact(input string tag, input logic [31:0] addr,
                        input logic wr, input logic [1:0] sz,
                        input logic un, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_cyc,
                        input int rsp_cyc, input logic e_err,
                        input logic [31:0] e_rdata, input logic [17:0] e_addr,
                        input logic [3:0] e_mask, input logic [31:0] e_wdata);
        i_req_valid    = 1'b1;
        i_req_addr     = addr;
        i_req_wren     = wr;
        i_req_size     = sz;
        i_req_unsigned = un;
        i_req_wdata    = wd;
        i_RDATA        = rd;
        for (int c = 1; c <= rsp_cyc + 1; c++) begin
            step();
            i_req_valid = 1'b0;
            i_ACK = (c == ack_cyc);
            if (c == 1 && !e_err) begin
                chk({tag, ".wren"},  32'(o_WREN), 32'(wr));
                chk({tag, ".rden"},  32'(o_RDEN), 32'(!wr));
                chk({tag, ".addr"},  32'(o_ADDR), 32'(e_addr));
                chk({tag, ".bmask"}, 32'(o_BMASK), 32'(e_mask));
                chk({tag, ".wdata"}, o_WDATA, e_wdata);
                chk({tag, ".ready1"}, 32'(o_req_ready), 32'd0);
            end else begin
                chk({tag, ".nostrobe"}, 32'({o_WREN, o_RDEN}), 32'd0);
            end
            if (c == rsp_cyc) begin
                chk({tag, ".rspv"},  32'(o_rsp_valid), 32'd1);
                chk({tag, ".err"},   32'(o_rsp_err), 32'(e_err));
                chk({tag, ".rdata"}, o_rsp_rdata, e_rdata);
            end else begin
                chk({tag, ".norsp"}, 32'(o_rsp_valid), 32'd0);
            end
            if (c == rsp_cyc + 1)
                chk({tag, ".readyback"}, 32'(o_req_ready), 32'd1);
        end
        i_ACK = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        i_req_valid    = 1'b0;
        i_req_addr     = 32'd0;
        i_req_wren     = 1'b0;
        i_req_size     = 2'd0;
        i_req_unsigned = 1'b0;
        i_req_wdata    = 32'd0;
        i_RDATA        = 32'd0;
        i_ACK          = 1'b0;

        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        xact("st_w", 32'h100, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,
             3, 4, 1'b0, 32'h0, 18'h080, 4'b1111, 32'hDEADBEEF);
        xact("ld_b_s", 32'h103, 1'b0, 2'b00, 1'b0, 32'h0, 32'h80FF1234,
             6, 7, 1'b0, 32'hFFFFFF80, 18'h080, 4'b1000, 32'h0);
        xact("ld_b_u", 32'h103, 1'b0, 2'b00, 1'b1, 32'h0, 32'h80FF1234,
             6, 7, 1'b0, 32'h00000080, 18'h080, 4'b1000, 32'h0);
        xact("st_h", 32'h0A, 1'b1, 2'b01, 1'b0, 32'h0000A5C3, 32'h0,
             3, 4, 1'b0, 32'h0, 18'h004, 4'b1100, 32'hA5C3A5C3);
        xact("ld_h_s", 32'h102, 1'b0, 2'b01, 1'b0, 32'h0, 32'h80FF1234,
             6, 7, 1'b0, 32'hFFFF80FF, 18'h080, 4'b1100, 32'h0);
        xact("ld_h_u", 32'h200, 1'b0, 2'b01, 1'b1, 32'h0, 32'h80FF9234,
             6, 7, 1'b0, 32'h00009234, 18'h100, 4'b0011, 32'h0);
        xact("st_b", 32'h101, 1'b1, 2'b00, 1'b0, 32'h1234565A, 32'h0,
             3, 4, 1'b0, 32'h0, 18'h080, 4'b0010, 32'h5A5A5A5A);
        xact("ld_w", 32'h0007_FFFC, 1'b0, 2'b10, 1'b0, 32'h0, 32'h12345678,
             6, 7, 1'b0, 32'h12345678, 18'h3FFFE, 4'b1111, 32'h0);

        xact("err_ldw", 32'h102, 1'b0, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF,
             0, 1, 1'b1, 32'h0, 18'h0, 4'h0, 32'h0);
        xact("err_rng", 32'h0008_0000, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0,
             0, 1, 1'b1, 32'h0, 18'h0, 4'h0, 32'h0);
        xact("err_sz", 32'h10, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0,
             0, 1, 1'b1, 32'h0, 18'h0, 4'h0, 32'h0);
        xact("err_half", 32'h101, 1'b1, 2'b01, 1'b0, 32'h0, 32'h0,
             0, 1, 1'b1, 32'h0, 18'h0, 4'h0, 32'h0);

        // Outputs to the controller keep their last issued values.
        chk("hold.addr",  32'(o_ADDR), 32'h3FFFE);
        chk("hold.bmask", 32'(o_BMASK), 32'hF);

        i_ACK = 1'b1;
        step();
        i_ACK = 1'b0;
        chk("idle_ack.rspv",  32'(o_rsp_valid), 32'd0);
        chk("idle_ack.ready", 32'(o_req_ready), 32'd1);
        step();

`ifdef SRAM_LSU_TIMEOUT_EN
        xact("tmo", 32'h104, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D,
             0, 17, 1'b1, 32'h0, 18'h082, 4'b1111, 32'h0);
        i_ACK = 1'b1;
        step();
        i_ACK = 1'b0;
        chk("tmo_stray.rspv",  32'(o_rsp_valid), 32'd0);
        chk("tmo_stray.ready", 32'(o_req_ready), 32'd1);
        step();
        chk("tmo_stray.rspv2", 32'(o_rsp_valid), 32'd0);
`endif

        // Reset while a load waits for its acknowledge.
        i_req_valid    = 1'b1;
        i_req_addr     = 32'h100;
        i_req_wren     = 1'b0;
        i_req_size     = 2'b10;
        i_req_unsigned = 1'b0;
        step();
        i_req_valid = 1'b0;
        chk("rst_pre.rden", 32'(o_RDEN), 32'd1);
        step();
        step();
        chk("rst_pre.ready", 32'(o_req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        i_ACK = 1'b1;
        step();
        i_ACK = 1'b0;
        chk("rst_post.rspv",  32'(o_rsp_valid), 32'd0);
        chk("rst_post.ready", 32'(o_req_ready), 32'd1);

        xact("st_after_rst", 32'h0A, 1'b1, 2'b01, 1'b0, 32'h0000A5C3, 32'h0,
             3, 4, 1'b0, 32'h0, 18'h004, 4'b1100, 32'hA5C3A5C3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
